// File: rtl/parking_gate_arbiter_pkg.sv
// Shared types and constants for the parking gate arbiter slice.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        OPEN  = 2'd2,
        CLEAR = 2'd3
    } lane_state_e;

    // Cycles after an entry decision before the next entry may be decided,
    // giving the counter time to update its vacancy flags.
    localparam int ENTRY_HOLDOFF = 2;

    localparam int TOTAL_SPACES     = 700;
    localparam int TOTAL_UNI_SPACES = 500;

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// Occupancy-update link between the gate arbiter (master) and the parking counter (slave).
interface parking_gate_arbiter_if;

    logic car_entered;
    logic is_uni_car_entered;
    logic car_exited;
    logic is_uni_car_exited;
    logic uni_space_avail;
    logic free_space_avail;

    modport master (
        output car_entered,
        output is_uni_car_entered,
        output car_exited,
        output is_uni_car_exited,
        input  uni_space_avail,
        input  free_space_avail
    );

    modport slave (
        input  car_entered,
        input  is_uni_car_entered,
        input  car_exited,
        input  is_uni_car_exited,
        output uni_space_avail,
        output free_space_avail
    );

endinterface

// File: rtl/parking_gate_arbiter_rr.sv
// Round-robin picker: one-hot grant starting at the lane after the last advanced grant.
module parking_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] gidx;
    logic [PW:0]   sum;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        gidx  = '0;
        sum   = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(off);
            if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
            if (!valid && req[sum[PW-1:0]]) begin
                valid                = 1'b1;
                grant[sum[PW-1:0]]   = 1'b1;
                gidx                 = sum[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= '0;
        else if (advance && valid)
            ptr_q <= (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;
    end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Entry/exit gate sequencer and single-event arbiter for the parking counter.
// Optional deny_count output enabled by macro PARK_DENY_COUNT_EN.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int N_ENTRY     = 2,
    parameter int N_EXIT      = 2,
    parameter int OPEN_CYCLES = 20,
    parameter int OPEN_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_ENTRY-1:0] entry_req,
    input  logic [N_ENTRY-1:0] entry_is_uni,
    input  logic [N_EXIT-1:0]  exit_req,
    input  logic [N_EXIT-1:0]  exit_is_uni,
    parking_gate_arbiter_if.master ctr,
    output logic [N_ENTRY-1:0] entry_gate_open,
    output logic [N_EXIT-1:0]  exit_gate_open,
    output logic [N_ENTRY-1:0] entry_denied,
    output logic               busy
`ifdef PARK_DENY_COUNT_EN
    ,
    output logic [15:0]        deny_count
`endif
);

    lane_state_e               entry_state_q [N_ENTRY];
    lane_state_e               entry_state_d [N_ENTRY];
    logic [OPEN_W-1:0]         entry_cnt_q   [N_ENTRY];
    logic [OPEN_W-1:0]         entry_cnt_d   [N_ENTRY];
    lane_state_e               exit_state_q  [N_EXIT];
    lane_state_e               exit_state_d  [N_EXIT];
    logic [OPEN_W-1:0]         exit_cnt_q    [N_EXIT];
    logic [OPEN_W-1:0]         exit_cnt_d    [N_EXIT];

    logic [N_ENTRY-1:0] entry_cand, entry_grant;
    logic [N_EXIT-1:0]  exit_cand, exit_grant;
    logic               entry_valid, exit_valid;
    logic               entry_decide, entry_ok, entry_no, sel_uni, sel_avail;
    logic [1:0]         holdoff_q;

    logic               car_entered_p1, is_uni_entered_p1;
    logic               car_exited_p1, is_uni_exited_p1;
    logic [N_ENTRY-1:0] entry_denied_p1;

    always_comb begin
        for (int i = 0; i < N_ENTRY; i++)
            entry_cand[i] = (entry_state_q[i] == PEND) && entry_req[i];
        for (int j = 0; j < N_EXIT; j++)
            exit_cand[j] = (exit_state_q[j] == PEND) && exit_req[j];
    end

    parking_rr_arbiter #(.N(N_EXIT)) u_exit_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (exit_cand),
        .advance (exit_valid),
        .grant   (exit_grant),
        .valid   (exit_valid)
    );

    parking_rr_arbiter #(.N(N_ENTRY)) u_entry_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (entry_cand),
        .advance (entry_decide),
        .grant   (entry_grant),
        .valid   (entry_valid)
    );

    // Exits always win the cycle; entries also wait out the holdoff window.
    always_comb begin
        entry_decide = entry_valid && !exit_valid && (holdoff_q == 2'd0);
        sel_uni      = |(entry_grant & entry_is_uni);
        sel_avail    = sel_uni ? ctr.uni_space_avail : ctr.free_space_avail;
        entry_ok     = entry_decide && sel_avail;
        entry_no     = entry_decide && !sel_avail;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENTRY; i++) begin
                entry_state_q[i] <= IDLE;
                entry_cnt_q[i]   <= '0;
            end
            for (int j = 0; j < N_EXIT; j++) begin
                exit_state_q[j] <= IDLE;
                exit_cnt_q[j]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_ENTRY; i++) begin
                entry_state_q[i] <= entry_state_d[i];
                entry_cnt_q[i]   <= entry_cnt_d[i];
            end
            for (int j = 0; j < N_EXIT; j++) begin
                exit_state_q[j] <= exit_state_d[j];
                exit_cnt_q[j]   <= exit_cnt_d[j];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_ENTRY; i++) begin
            entry_state_d[i] = entry_state_q[i];
            entry_cnt_d[i]   = entry_cnt_q[i];
            unique case (entry_state_q[i])
                IDLE:  if (entry_req[i]) entry_state_d[i] = PEND;
                PEND: begin
                    if (!entry_req[i]) begin
                        entry_state_d[i] = IDLE;
                    end else if (entry_grant[i] && entry_ok) begin
                        entry_state_d[i] = OPEN;
                        entry_cnt_d[i]   = OPEN_W'(OPEN_CYCLES);
                    end else if (entry_grant[i] && entry_no) begin
                        entry_state_d[i] = CLEAR;
                    end
                end
                OPEN: begin
                    entry_cnt_d[i] = entry_cnt_q[i] - 1'b1;
                    if (entry_cnt_q[i] <= OPEN_W'(1)) entry_state_d[i] = CLEAR;
                end
                CLEAR: if (!entry_req[i]) entry_state_d[i] = IDLE;
                default: entry_state_d[i] = IDLE;
            endcase
        end
        for (int j = 0; j < N_EXIT; j++) begin
            exit_state_d[j] = exit_state_q[j];
            exit_cnt_d[j]   = exit_cnt_q[j];
            unique case (exit_state_q[j])
                IDLE:  if (exit_req[j]) exit_state_d[j] = PEND;
                PEND: begin
                    if (!exit_req[j]) begin
                        exit_state_d[j] = IDLE;
                    end else if (exit_grant[j]) begin
                        exit_state_d[j] = OPEN;
                        exit_cnt_d[j]   = OPEN_W'(OPEN_CYCLES);
                    end
                end
                OPEN: begin
                    exit_cnt_d[j] = exit_cnt_q[j] - 1'b1;
                    if (exit_cnt_q[j] <= OPEN_W'(1)) exit_state_d[j] = CLEAR;
                end
                CLEAR: if (!exit_req[j]) exit_state_d[j] = IDLE;
                default: exit_state_d[j] = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < N_ENTRY; i++) begin
            entry_gate_open[i] = (entry_state_q[i] == OPEN);
            if (entry_state_q[i] != IDLE) busy = 1'b1;
        end
        for (int j = 0; j < N_EXIT; j++) begin
            exit_gate_open[j] = (exit_state_q[j] == OPEN);
            if (exit_state_q[j] != IDLE) busy = 1'b1;
        end
    end

    // Stage p1: registered counter events, one cycle after the decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            car_entered_p1    <= 1'b0;
            is_uni_entered_p1 <= 1'b0;
            car_exited_p1     <= 1'b0;
            is_uni_exited_p1  <= 1'b0;
            entry_denied_p1   <= '0;
            holdoff_q         <= 2'd0;
        end else begin
            car_entered_p1    <= entry_ok;
            is_uni_entered_p1 <= entry_ok && sel_uni;
            car_exited_p1     <= exit_valid;
            is_uni_exited_p1  <= exit_valid && |(exit_grant & exit_is_uni);
            entry_denied_p1   <= entry_no ? entry_grant : '0;
            if (entry_decide)
                holdoff_q <= 2'(ENTRY_HOLDOFF);
            else if (holdoff_q != 2'd0)
                holdoff_q <= holdoff_q - 2'd1;
        end
    end

    assign ctr.car_entered        = car_entered_p1;
    assign ctr.is_uni_car_entered = is_uni_entered_p1;
    assign ctr.car_exited         = car_exited_p1;
    assign ctr.is_uni_car_exited  = is_uni_exited_p1;
    assign entry_denied           = entry_denied_p1;

`ifdef PARK_DENY_COUNT_EN
    logic [15:0] deny_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            deny_count_q <= '0;
        else if (|entry_denied_p1 && deny_count_q != 16'hFFFF)
            deny_count_q <= deny_count_q + 16'd1;
    end

    assign deny_count = deny_count_q;
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter with hand-computed cycle expectations.
module tb_parking_gate_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] entry_req, entry_is_uni, exit_req, exit_is_uni;
    logic [1:0] entry_gate_open, exit_gate_open, entry_denied;
    logic       busy;
`ifdef PARK_DENY_COUNT_EN
    logic [15:0] deny_count;
`endif

    parking_gate_arbiter_if ctr_if ();

    parking_gate_arbiter #(
        .N_ENTRY(2), .N_EXIT(2), .OPEN_CYCLES(20), .OPEN_W(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .entry_req       (entry_req),
        .entry_is_uni    (entry_is_uni),
        .exit_req        (exit_req),
        .exit_is_uni     (exit_is_uni),
        .ctr             (ctr_if),
        .entry_gate_open (entry_gate_open),
        .exit_gate_open  (exit_gate_open),
        .entry_denied    (entry_denied),
        .busy            (busy)
`ifdef PARK_DENY_COUNT_EN
        ,
        .deny_count      (deny_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic deny_case(input string tag, input logic uni, input logic ua, input logic fa);
        int first_k, denies, entered, opens;
        first_k = -1; denies = 0; entered = 0; opens = 0;
        entry_is_uni = {1'b0, uni};
        ctr_if.uni_space_avail  = ua;
        ctr_if.free_space_avail = fa;
        entry_req = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (entry_denied == 2'b01) begin
                denies++;
                if (first_k < 0) first_k = k;
            end
            if (ctr_if.car_entered) entered++;
            if (entry_gate_open[0]) opens++;
        end
        chk({tag, "_deny_cycle"}, first_k, 2);
        chk({tag, "_deny_pulses"}, denies, 1);
        chk({tag, "_no_entered"}, entered, 0);
        chk({tag, "_gate_closed"}, opens, 0);
        chk({tag, "_busy_clear"}, busy, 1);
        entry_req = 2'b00;
        tick();
        chk({tag, "_idle_after_drop"}, busy, 0);
    endtask

    initial begin
        int opens, pulses, t_ex, t_en, both, uni_ex, uni_en;
        int seq[4];
        int tg[4];
        int ng;
        logic [1:0] prev;

        rst = 1'b1;
        entry_req = '0; entry_is_uni = '0; exit_req = '0; exit_is_uni = '0;
        ctr_if.uni_space_avail = 1'b0; ctr_if.free_space_avail = 1'b0;
        tick(); tick();
        chk("rst_car_entered", ctr_if.car_entered, 0);
        chk("rst_car_exited", ctr_if.car_exited, 0);
        chk("rst_gates", {entry_gate_open, exit_gate_open}, 0);
        chk("rst_denied_busy", {entry_denied, busy}, 0);
        rst = 1'b0;

        // Uni entry granted once, gate held 20 cycles, held request gives no second event
        entry_is_uni = 2'b01;
        ctr_if.uni_space_avail = 1'b1; ctr_if.free_space_avail = 1'b1;
        entry_req = 2'b01;
        tick();
        chk("t1_pend_no_evt", ctr_if.car_entered, 0);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_entered", ctr_if.car_entered, 1);
        chk("t1_is_uni", ctr_if.is_uni_car_entered, 1);
        chk("t1_gate_up", entry_gate_open, 2'b01);
        opens = 0; pulses = 0;
        for (int k = 0; k < 30; k++) begin
            if (entry_gate_open[0]) opens++;
            if (ctr_if.car_entered) pulses++;
            tick();
        end
        chk("t1_open_len", opens, 20);
        chk("t1_one_pulse", pulses, 1);
        chk("t1_gate_down", entry_gate_open, 0);
        chk("t1_clear_busy", busy, 1);
        entry_req = 2'b00;
        tick();
        chk("t1_idle", busy, 0);

        // Simultaneous exit and entry: exit first, entry one cycle later
        entry_is_uni = 2'b00; exit_is_uni = 2'b01;
        entry_req = 2'b10; exit_req = 2'b01;
        t_ex = -1; t_en = -1; both = 0; uni_ex = -1; uni_en = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (ctr_if.car_exited && ctr_if.car_entered) both++;
            if (ctr_if.car_exited && t_ex < 0) begin t_ex = k; uni_ex = ctr_if.is_uni_car_exited; end
            if (ctr_if.car_entered && t_en < 0) begin t_en = k; uni_en = ctr_if.is_uni_car_entered; end
        end
        chk("t2_exit_cycle", t_ex, 2);
        chk("t2_entry_cycle", t_en, 3);
        chk("t2_never_both", both, 0);
        chk("t2_exit_uni", uni_ex, 1);
        chk("t2_entry_free", uni_en, 0);
        chk("t2_gates", {entry_gate_open, exit_gate_open}, 4'b1001);
        entry_req = 2'b00; exit_req = 2'b00;
        for (int k = 0; k < 30; k++) tick();
        chk("t2_idle", busy, 0);

        // Denials for each vacancy class
        deny_case("t3_free_full", 1'b0, 1'b1, 1'b0);
        deny_case("t3_uni_full", 1'b1, 1'b0, 1'b1);
`ifdef PARK_DENY_COUNT_EN
        deny_case("t3_third", 1'b0, 1'b1, 1'b0);
        tick();
        chk("t3_deny_count", deny_count, 3);
        force dut.deny_count_q = 16'hFFFF;
        tick();
        release dut.deny_count_q;
        deny_case("t3_sat", 1'b0, 1'b1, 1'b0);
        tick();
        chk("t3_deny_sat", deny_count, 16'hFFFF);
`endif

        // Reset returns round-robin pointers to lane 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Two entry lanes contending: alternate grants with holdoff spacing
        entry_is_uni = 2'b00;
        ctr_if.free_space_avail = 1'b1; ctr_if.uni_space_avail = 1'b1;
        entry_req = 2'b11;
        prev = 2'b00; ng = 0; both = 0;
        for (int k = 1; k <= 120 && ng < 4; k++) begin
            tick();
            if (ctr_if.car_exited && ctr_if.car_entered) both++;
            if (ctr_if.car_entered) begin
                for (int i = 0; i < 2; i++)
                    if (entry_gate_open[i] && !prev[i] && ng < 4) begin
                        seq[ng] = i; tg[ng] = k; ng++;
                    end
            end
            for (int i = 0; i < 2; i++)
                entry_req[i] = !(prev[i] && !entry_gate_open[i]);
            prev = entry_gate_open;
        end
        chk("t4_grant_count", ng, 4);
        chk("t4_seq0", seq[0], 0);
        chk("t4_seq1", seq[1], 1);
        chk("t4_seq2", seq[2], 0);
        chk("t4_seq3", seq[3], 1);
        chk("t4_holdoff_gap", tg[1] - tg[0], 3);
        chk("t4_gap_min", ((tg[2] - tg[1]) >= 3 && (tg[3] - tg[2]) >= 3), 1);
        entry_req = 2'b00;
        for (int k = 0; k < 30; k++) tick();
        chk("t4_idle", busy, 0);

        // Async reset mid-hold on exit lane 1, then a single fresh exit event
        exit_is_uni = 2'b00;
        exit_req = 2'b10;
        tick(); tick();
        chk("t5_exited", ctr_if.car_exited, 1);
        for (int k = 0; k < 10; k++) tick();
        chk("t5_gate_mid", exit_gate_open, 2'b10);
        rst = 1'b1;
        #1;
        chk("t5_gate_async_close", exit_gate_open, 0);
        chk("t5_busy_reset", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        t_ex = -1; pulses = 0; opens = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (ctr_if.car_exited) begin
                pulses++;
                if (t_ex < 0) t_ex = k;
            end
            if (exit_gate_open[1]) opens++;
        end
        chk("t5_reexit_cycle", t_ex, 2);
        chk("t5_reexit_pulses", pulses, 1);
        chk("t5_reopen_len", opens, 20);
        chk("t5_no_entry", ctr_if.car_entered, 0);
        exit_req = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
